// File: rtl/imm_encoder_pkg.sv
// imm_encoder_pkg: RV32 major-opcode constants, the internal instruction
// format enum and the opcode-to-format decoder shared by the encoder and
// its packing sub-block.
package imm_encoder_pkg;

    localparam logic [6:0] OP_I_LOAD  = 7'h03;
    localparam logic [6:0] OP_I_COMP  = 7'h13;
    localparam logic [6:0] OP_U_AUIPC = 7'h17;
    localparam logic [6:0] OP_S       = 7'h23;
    localparam logic [6:0] OP_R       = 7'h33;
    localparam logic [6:0] OP_U_LUI   = 7'h37;
    localparam logic [6:0] OP_B       = 7'h63;
    localparam logic [6:0] OP_I_JALR  = 7'h67;
    localparam logic [6:0] OP_J       = 7'h6F;
    localparam logic [6:0] OP_I_ENV   = 7'h73;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0013;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_ENV, FMT_S, FMT_B, FMT_U, FMT_J, FMT_UNK
    } fmt_e;

    function automatic fmt_e decode_fmt(input logic [6:0] op);
        case (op)
            OP_I_COMP, OP_I_LOAD, OP_I_JALR: return FMT_I;
            OP_I_ENV:                        return FMT_ENV;
            OP_S:                            return FMT_S;
            OP_B:                            return FMT_B;
            OP_J:                            return FMT_J;
            OP_U_LUI, OP_U_AUIPC:            return FMT_U;
            OP_R:                            return FMT_R;
            default:                         return FMT_UNK;
        endcase
    endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// imm_encoder_if: input and output handshake bundle of the immediate encoder.
//   in_valid/in_ready + field bus : beat from loader / self-modifying-code path
//   out_valid/out_ready/out_instr/out_err : word to instruction-memory write port
//   out_count : running count of words accepted downstream (CNT_W bits, wraps)
// Modports: slave = encoder side, master = producer/consumer side.
interface imm_encoder_if #(
    parameter int CNT_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [6:0]        in_opcode;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [11:0]       in_csr;
    logic [31:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic              out_err;
    logic [CNT_W-1:0]  out_count;

    modport slave (
        input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3,
               in_funct7, in_csr, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_err, out_count
    );

    modport master (
        output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3,
               in_funct7, in_csr, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_err, out_count
    );
endinterface

// File: rtl/imm_encoder_packer.sv
// imm_encoder_packer: combinational imm_packer block. Scatters a flat
// immediate and the register fields into the bit positions of the selected
// RV32 format. Unknown formats produce NOP_WORD.
// Ports: fmt, opcode, rd, rs1, rs2, funct3, funct7, csr, imm in; word out.
module imm_encoder_packer
    import imm_encoder_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  fmt_e               fmt,
    input  logic [6:0]         opcode,
    input  logic [4:0]         rd,
    input  logic [4:0]         rs1,
    input  logic [4:0]         rs2,
    input  logic [2:0]         funct3,
    input  logic [6:0]         funct7,
    input  logic [11:0]        csr,
    input  logic signed [31:0] imm,
    output logic [31:0]        word
);

    always_comb begin
        word = NOP_WORD;
        case (fmt)
            FMT_R:   word = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I:   word = {imm[11:0], rs1, funct3, rd, opcode};
            // CSR immediate forms (funct3[2]) carry uimm in the rs1 slot
            FMT_ENV: word = {csr, (funct3[2] ? imm[4:0] : rs1), funct3, rd, opcode};
            FMT_S:   word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B:   word = {imm[12], imm[10:5], rs2, rs1, funct3,
                             imm[4:1], imm[11], opcode};
            FMT_U:   word = {imm[31:12], rd, opcode};
            FMT_J:   word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: word = NOP_WORD;
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// imm_encoder: two-stage valid/ready pipeline packing opcode, register
// fields and a flat immediate into an RV32 instruction word.
//   stage 1: latch fields, decode format, compute error flag
//   stage 2: packed word register driving out_instr / out_err
// Ports: clock, reset (sync, active-low), bus (imm_encoder_if.slave).
// Build option: define IMM_RANGE_CHECK_EN to flag immediates that the
// selected format cannot represent exactly; otherwise out_err only marks
// unknown opcodes.
module imm_encoder
    import imm_encoder_pkg::*;
#(
    parameter int          CNT_W    = 16,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic          clock,
    input  logic          reset,
    imm_encoder_if.slave  bus
);

`ifdef IMM_RANGE_CHECK_EN
    function automatic logic range_err(input fmt_e fmt,
                                       input logic signed [31:0] imm,
                                       input logic [2:0] funct3);
        case (fmt)
            FMT_I, FMT_S: return (imm < -32'sd2048) || (imm > 32'sd2047);
            FMT_B:        return imm[0] || (imm < -32'sd4096) || (imm > 32'sd4094);
            FMT_J:        return imm[0] || (imm < -32'sd1048576) || (imm > 32'sd1048574);
            FMT_U:        return imm[11:0] != 12'd0;
            FMT_ENV:      return funct3[2] && (imm[31:5] != 27'd0);
            default:      return 1'b0;
        endcase
    endfunction
`endif

    logic               vld_p1, vld_p2;
    logic               advance;
    fmt_e               fmt_in;
    logic               err_in;

    fmt_e               fmt_p1;
    logic [6:0]         opcode_p1, funct7_p1;
    logic [4:0]         rd_p1, rs1_p1, rs2_p1;
    logic [2:0]         funct3_p1;
    logic [11:0]        csr_p1;
    logic signed [31:0] imm_p1;
    logic               err_p1;

    logic [31:0]        word_p1;
    logic [31:0]        instr_p2;
    logic               err_p2;
    logic [CNT_W-1:0]   count;

    assign advance      = !vld_p2 || bus.out_ready;
    assign bus.in_ready = !vld_p1 || advance;
    assign fmt_in       = decode_fmt(bus.in_opcode);

`ifdef IMM_RANGE_CHECK_EN
    assign err_in = (fmt_in == FMT_UNK) ||
                    range_err(fmt_in, $signed(bus.in_imm), bus.in_funct3);
`else
    assign err_in = (fmt_in == FMT_UNK);
`endif

    // ---- stage 1: field latch, format decode, error flag ----
    always_ff @(posedge clock) begin
        if (!reset)
            vld_p1 <= 1'b0;
        else if (bus.in_ready)
            vld_p1 <= bus.in_valid;
    end

    always_ff @(posedge clock) begin
        if (bus.in_valid && bus.in_ready) begin
            fmt_p1    <= fmt_in;
            opcode_p1 <= bus.in_opcode;
            rd_p1     <= bus.in_rd;
            rs1_p1    <= bus.in_rs1;
            rs2_p1    <= bus.in_rs2;
            funct3_p1 <= bus.in_funct3;
            funct7_p1 <= bus.in_funct7;
            csr_p1    <= bus.in_csr;
            imm_p1    <= $signed(bus.in_imm);
            err_p1    <= err_in;
        end
    end

    imm_encoder_packer #(
        .NOP_WORD (NOP_WORD)
    ) u_packer (
        .fmt    (fmt_p1),
        .opcode (opcode_p1),
        .rd     (rd_p1),
        .rs1    (rs1_p1),
        .rs2    (rs2_p1),
        .funct3 (funct3_p1),
        .funct7 (funct7_p1),
        .csr    (csr_p1),
        .imm    (imm_p1),
        .word   (word_p1)
    );

    // ---- stage 2: packed word / error output register ----
    always_ff @(posedge clock) begin
        if (!reset) begin
            vld_p2   <= 1'b0;
            instr_p2 <= 32'd0;
            err_p2   <= 1'b0;
        end else if (advance) begin
            vld_p2 <= vld_p1;
            // hold the last word when the stage drains empty
            if (vld_p1) begin
                instr_p2 <= word_p1;
                err_p2   <= err_p1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset)
            count <= '0;
        else if (vld_p2 && bus.out_ready)
            count <= count + 1'b1;
    end

    assign bus.out_valid = vld_p2;
    assign bus.out_instr = instr_p2;
    assign bus.out_err   = err_p2;
    assign bus.out_count = count;

endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: directed bench for imm_encoder with an expected-word
// scoreboard queue filled at stimulus time and drained by an output monitor.
module tb_imm_encoder;
    import imm_encoder_pkg::*;

    localparam int CNT_W = 4;
`ifdef IMM_RANGE_CHECK_EN
    localparam logic RC = 1'b1;
`else
    localparam logic RC = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cnt_model = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    imm_encoder_if #(.CNT_W(CNT_W)) bus ();

    imm_encoder #(.CNT_W(CNT_W)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // output monitor: a transfer happens at the next rising edge
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL unexpected_word: observed=%h expected=none", bus.out_instr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_instr", bus.out_instr, e.instr);
                check("out_err", {31'd0, bus.out_err}, {31'd0, e.err});
            end
            cnt_model++;
        end
    end

    task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [11:0] csr, input logic [31:0] imm,
                        input logic [31:0] exp_instr, input logic exp_err);
        bus.in_opcode = op;  bus.in_rd = rd;   bus.in_rs1 = rs1; bus.in_rs2 = rs2;
        bus.in_funct3 = f3;  bus.in_funct7 = f7; bus.in_csr = csr; bus.in_imm = imm;
        bus.in_valid  = 1'b1;
        exp_q.push_back('{instr: exp_instr, err: exp_err});
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk);
                #1 bus.in_valid = 1'b0;
                return;
            end
        end
        checks++;
        failures++;
        $error("FAIL accept_timeout: observed=in_ready_low expected=accept");
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        for (t = 0; t < 100; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.out_valid) break;
        end
        checks++;
        assert (t < 100) else begin
            failures++;
            $error("FAIL drain_timeout: observed=%0d pending expected=0", exp_q.size());
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.delete();
        cnt_model = 0;
    endtask

    logic [31:0] held;

    initial begin
        bus.in_valid = 1'b0; bus.in_opcode = '0; bus.in_rd = '0; bus.in_rs1 = '0;
        bus.in_rs2 = '0; bus.in_funct3 = '0; bus.in_funct7 = '0; bus.in_csr = '0;
        bus.in_imm = '0; bus.out_ready = 1'b1;

        do_reset();
        @(negedge clk);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_instr", bus.out_instr, 32'd0);
        check("rst_out_err", {31'd0, bus.out_err}, 32'd0);
        check("rst_out_count", {28'd0, bus.out_count}, 32'd0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // addi x1, x0, 5 with latency check
        @(posedge clk); #1;
        send(OP_I_COMP, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 32'd5, 32'h00500093, 1'b0);
        @(negedge clk);
        check("lat_not_yet", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        check("lat_valid", {31'd0, bus.out_valid}, 32'd1);
        @(posedge clk); #1;

        send(OP_B, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 12'd0, 32'hFFFF_FFFC, 32'hFE208EE3, 1'b0);
        send(OP_B, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 12'd0, 32'd3, 32'h00208163, RC);
        send(OP_J, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 32'h000F_FFFE, 32'h7FFFF06F, 1'b0);
        send(OP_J, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 32'h0010_0000, 32'h8000006F, RC);
        send(7'h7F, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 12'd0, 32'd0, 32'h00000013, 1'b1);
        send(OP_S, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 12'd0, 32'hFFFF_FFF8, 32'hFE20AC23, 1'b0);
        send(OP_U_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 32'h1234_5000, 32'h123452B7, 1'b0);
        send(OP_U_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 32'h1234_5678, 32'h123452B7, RC);
        send(OP_I_ENV, 5'd3, 5'd9, 5'd0, 3'd5, 7'd0, 12'h300, 32'd7, 32'h3003D1F3, 1'b0);
        send(OP_I_ENV, 5'd3, 5'd9, 5'd0, 3'd5, 7'd0, 12'h300, 32'd39, 32'h3003D1F3, RC);
        send(OP_R, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 12'd0, 32'd0, 32'h402081B3, 1'b0);
        send(OP_I_COMP, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 32'd2048, 32'h80000093, RC);
        drain();
        check("count_model", {28'd0, bus.out_count}, cnt_model & 32'hF);

        // backpressure: four beats against a 5-cycle stall
        do_reset();
        @(posedge clk); #1 bus.out_ready = 1'b0;
        fork
            begin
                for (int k = 1; k <= 4; k++)
                    send(OP_I_COMP, k[4:0], 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, k,
                         (k << 20) | (k << 7) | 32'h13, 1'b0);
            end
            begin
                repeat (3) @(negedge clk);
                check("bp_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
                check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
                held = bus.out_instr;
                check("bp_head_word", held, 32'h00100093);
                repeat (2) begin
                    @(negedge clk);
                    check("bp_stable", bus.out_instr, held);
                    check("bp_in_ready_held", {31'd0, bus.in_ready}, 32'd0);
                end
                @(posedge clk); #1 bus.out_ready = 1'b1;
            end
        join
        drain();
        check("bp_count", {28'd0, bus.out_count}, 32'd4);

        // reset with both stages full
        @(posedge clk); #1 bus.out_ready = 1'b0;
        send(OP_I_COMP, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 32'd7, 32'h00700393, 1'b0);
        send(OP_I_COMP, 5'd8, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 32'd8, 32'h00800413, 1'b0);
        #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        exp_q.delete();
        cnt_model = 0;
        @(negedge clk);
        check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mid_rst_out_count", {28'd0, bus.out_count}, 32'd0);
        check("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk); #1 bus.out_ready = 1'b1;

        // counter wrap with 4-bit counter
        for (int k = 0; k < 17; k++)
            send(OP_I_COMP, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, k, (k << 20) | 32'h113, 1'b0);
        drain();
        check("wrap_count", {28'd0, bus.out_count}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the decode-side immediate selection: packs opcode, register fields and a flat 32-bit immediate into a legal RV32 instruction word.
- Immediate bits are scattered to the format-specific positions selected by opcode.
- Two-stage valid/ready pipeline sitting between the test-program loader / self-modifying-code path and instruction memory write port.
- Flags immediates that cannot be encoded exactly and keeps a running emitted-instruction count.

Parameters:
CNT_W, 16, width of emitted-instruction counter
NOP_WORD, 32'h00000013, word emitted for unknown opcode

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  encoder can accept a beat
in_opcode  in  7  RV32 major opcode (shared opcode constants)
in_rd  in  5  destination register
in_rs1  in  5  source register 1
in_rs2  in  5  source register 2
in_funct3  in  3  funct3
in_funct7  in  7  funct7 (R-format only)
in_csr  in  12  CSR address (I_ENV only)
in_imm  in  32  flat sign-extended immediate (byte offset for B/J, full value for U)
out_valid  out  1  instruction word valid
out_ready  in  1  downstream accepts word
out_instr  out  32  encoded instruction
out_err  out  1  immediate not exactly encodable or unknown opcode; qualified by out_valid
out_count  out  CNT_W  number of words accepted downstream, wraps

Behaviour:
- Reset (reset==0 at clock edge) clears:
  - both stage valids, out_valid=0, out_instr=0, out_err=0, out_count=0.
  - Reset mid-operation discards in-flight beats; in_ready is 1 the cycle after release.
- Handshake:
  - Input transfer on in_valid&&in_ready; output transfer on out_valid&&out_ready.
  - out_instr and out_err stay stable while out_valid&&!out_ready.
- Stage 1 (registered): latch fields; decode format (I_COMP/I_LOAD/I_JALR=I, I_ENV, S, B, J, U_LUI/U_AUIPC=U, R, else UNKNOWN); compute range error.
- Stage 2 (registered): pack word; this register drives out_instr and out_err.
- Pipeline control:
  - s2 loads when !s2_valid || out_ready.
  - s1 advances under the same condition; in_ready = !s1_valid || that condition.
  - Latency: 2 cycles accept-to-out_valid; throughput 1 word/cycle with out_ready held high.
  - Simultaneous accept and emit in the same cycle is legal, with no bubble.
- Packing (bits [6:0]=opcode in all cases, except UNKNOWN):
  - R: [31:25]=funct7, [24:20]=rs2, [19:15]=rs1, [14:12]=funct3, [11:7]=rd.
  - I: [31:20]=imm[11:0], rs1, funct3, rd.
  - I_ENV: [31:20]=in_csr; [19:15]=imm[4:0] if funct3[2] else rs1; funct3, rd.
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0], rs2, rs1, funct3.
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11], rs2, rs1, funct3.
  - U: [31:12]=imm[31:12], rd.
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12], rd.
  - UNKNOWN: out_instr=NOP_WORD, out_err=1.
- out_count increments on each output transfer; wraps from all-ones to 0.

Optional Feature:
IMM_RANGE_CHECK_EN
- Defined: out_err=1 when the immediate is not exactly representable:
  - I/S: imm not in [-2048,2047].
  - B: imm[0]!=0 or imm not in [-4096,4094].
  - J: imm[0]!=0 or imm not in [-2^20, 2^20-2].
  - U: imm[11:0]!=0.
  - I_ENV with funct3[2]: imm[31:5]!=0.
  - The word is still packed from the truncated bits.
- Undefined: out_err asserts only for UNKNOWN opcode; no range logic is synthesised.

Decomposition:
- Shared package / include (constants.vh): opcode format constants, internal format enum (FMT_R, FMT_I, FMT_ENV, FMT_S, FMT_B, FMT_U, FMT_J, FMT_UNK), NOP_WORD default.
- One combinational sub-module, imm_packer: inputs format, fields and imm; output 32-bit word.
- The pipeline, handshake, range check and counter live in imm_encoder.

Test Plan:
- I-format: opcode=I_COMP, rd=1, rs1=0, funct3=0, imm=5 -> out_instr=32'h00500093 two cycles after accept; out_err=0.
- B-format: rs1=1, rs2=2, funct3=0, imm=-4 -> out_instr=32'hFE208EE3; with IMM_RANGE_CHECK_EN, imm=3 -> out_err=1.
- J-format: rd=0, imm=32'h000FFFFE -> [31]=0, [30:21]=10'h3FF, [20]=1, [19:12]=8'hFF; imm=2^20 with the macro defined -> out_err=1.
- Backpressure: stream 4 beats with out_ready=0 for 5 cycles:
  - in_ready drops after 2 accepted beats.
  - out_instr is stable while stalled.
  - After release, all 4 words arrive in order with no loss or duplication; out_count=4.
- Unknown opcode 7'h7F -> out_instr=32'h00000013, out_err=1.
- Reset with both stages full -> next cycle out_valid=0, out_count=0, in_ready=1.
- Counter wrap: CNT_W=4, emit 17 words -> out_count=1.
